ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset)
//  to the keyboard over the shared PS2_CLK/PS2_DAT lines, mirroring the keyboard scan receiver.
//  Drives lines open-drain via active-high pull-low enables; top level ties pad = oe ? 1'b0 : 1'bz.
//  Asserts rx_mask while busy so the scan-code receiver ignores transmit-phase clocks.
// PARAMETERS
//  INHIBIT_CYC   6000     clk50 cycles PS2_CLK held low before request (120 us)
//  START_TO_CYC  750000   max cycles from clock release to first device falling edge (15 ms)
//  PKT_TO_CYC    100000   max cycles from first falling edge to ACK (2 ms)
//  FILT_LEN      8        consecutive equal samples required to accept a line level change
// PORTS
//  clk50        in   1  system clock, 50 MHz
//  RST          in   1  asynchronous reset, active-low
//  tx_data      in   8  command byte to send
//  tx_valid     in   1  request; byte accepted when tx_valid & tx_ready
//  tx_ready     out  1  high only in IDLE
//  PS2_CLK      in   1  pad clock level (asynchronous)
//  PS2_DAT      in   1  pad data level (asynchronous)
//  ps2_clk_oe   out  1  1 = pull PS2_CLK low
//  ps2_dat_oe   out  1  1 = pull PS2_DAT low
//  rx_mask      out  1  1 = receiver must discard clocks
//  tx_done      out  1  one-cycle pulse: byte sent and ACKed
//  tx_err       out  1  one-cycle pulse: timeout or missing ACK
// BEHAVIOUR
//  - Reset (RST=0, async): state IDLE; ps2_clk_oe=0, ps2_dat_oe=0, rx_mask=0, tx_done=0,
//    tx_err=0, tx_ready=1, counters 0. Lines are released immediately, including mid-frame.
//  - Inputs: 2-flop synchroniser, then FILT_LEN glitch filter; fall = filtered clk 1->0.
//  - Frame: {stop=1, parity=~^tx_data, tx_data[7:0]} latched at accept; shifted out LSB first.
//  - FSM:
//    IDLE:    accept -> INHIBIT; clk_oe=1, rx_mask=1, cnt=0.
//    INHIBIT: cnt==INHIBIT_CYC-1 -> REQ; dat_oe=1 (start bit 0), clk_oe=0, cnt=0.
//    REQ:     first fall -> BITS; dat_oe=~data[0], bitcnt=1, cnt=0.
//             cnt==START_TO_CYC-1 -> ERR.
//    BITS:    each fall drives the next frame bit on dat_oe (inverted level); falls 2..8 send
//             d1..d7, fall 9 sends parity, fall 10 sends stop (dat_oe=0). After fall 10 -> ACK.
//    ACK:     at fall 11 sample filtered data: 0 -> REL, 1 -> ERR.
//    REL:     wait filtered clk=1 and data=1 -> DONE.
//    DONE:    tx_done=1 for 1 cycle; -> IDLE.
//    ERR:     tx_err=1 for 1 cycle, both oe=0; -> IDLE.
//    The PKT_TO_CYC counter runs in BITS/ACK/REL; cnt==PKT_TO_CYC-1 -> ERR.
//  - rx_mask=1 from accept until the IDLE re-entry cycle; 0 in IDLE.
//  - tx_valid outside IDLE is ignored (no queue); upstream holds it until tx_ready.
//  - Device clocks during INHIBIT are ignored (host wins); falls in INHIBIT do not count.
//  - Latency accept->tx_done ~ INHIBIT_CYC + device 11 clocks (~1.1 ms @ 10 kHz) + filter delays.
// TESTING
//  1 Send 8'hED; device model at 12.5 kHz ACKs -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
//    single tx_done; tx_err never.
//  2 Send 8'hF4 -> parity bit 0 observed at fall 9; tx_done.
//  3 Device never clocks after REQ -> tx_err exactly START_TO_CYC cycles (+/- filter) after
//    REQ entry; both oe=0; tx_ready=1 next cycle.
//  4 Device leaves data high at fall 11 -> tx_err, no tx_done.
//  5 Assert RST=0 at fall 5 -> oe outputs 0 in the same cycle (async); after release, state IDLE;
//    next 8'hFF send succeeds.
//  6 1-cycle 20 ns glitches on PS2_CLK during BITS -> no extra bits; frame still correct;
//    tx_valid pulsed while busy -> ignored.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-byte handshake between a requester and the PS/2 host transmitter
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   logic tx_done;
   logic tx_err;
   modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_err);
   modport slave (input tx_data, tx_valid, output tx_ready, tx_done, tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: open-drain PS/2 host-to-device command transmitter with timeouts and ACK check
module ps2_host_tx #(
   parameter int INHIBIT_CYC = 6000,
   parameter int START_TO_CYC = 750000,
   parameter int PKT_TO_CYC = 100000,
   parameter int FILT_LEN = 8
) (
   input logic clk50,
   input logic RST,
   ps2_host_tx_if.slave tx,
   input logic PS2_CLK,
   input logic PS2_DAT,
   output logic ps2_clk_oe,
   output logic ps2_dat_oe,
   output logic rx_mask
);
   localparam int MX = INHIBIT_CYC > START_TO_CYC ? (INHIBIT_CYC > PKT_TO_CYC ? INHIBIT_CYC : PKT_TO_CYC) : (START_TO_CYC > PKT_TO_CYC ? START_TO_CYC : PKT_TO_CYC);
   localparam int CW = $clog2(MX) > 0 ? $clog2(MX) : 1;
   localparam int FW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, REL, DONE, ERR} state_t;
   state_t state;
   logic [1:0] m0, m1, lf;
   logic clk_d;
   logic [FW-1:0] fc [2];
   logic [CW-1:0] cnt;
   logic [9:0] sh;
   logic [3:0] bitcnt;
   logic fall, pkt, go_err;
   always_comb begin
      fall = clk_d & ~lf[0];
      pkt = state == BITS || state == ACK || state == REL;
      go_err = (state == REQ && !fall && cnt == CW'(START_TO_CYC - 1)) || (pkt && cnt == CW'(PKT_TO_CYC - 1)) || (state == ACK && fall && lf[1]);
   end
   // index 0 is the clock line, index 1 the data line; idle level of both is high
   always_ff @(posedge clk50 or negedge RST)
      if (!RST) begin
         m0 <= '1;
         m1 <= '1;
         lf <= '1;
         clk_d <= 1'b1;
         fc <= '{default: '0};
      end else begin
         m0 <= {PS2_DAT, PS2_CLK};
         m1 <= m0;
         clk_d <= lf[0];
         for (int i = 0; i < 2; i++)
            if (m1[i] == lf[i]) fc[i] <= '0;
            else if (fc[i] == FW'(FILT_LEN - 1)) begin
               lf[i] <= m1[i];
               fc[i] <= '0;
            end else fc[i] <= fc[i] + 1'b1;
      end
   always_ff @(posedge clk50 or negedge RST)
      if (!RST) begin
         state <= IDLE;
         cnt <= '0;
         sh <= '0;
         bitcnt <= '0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         rx_mask <= 1'b0;
         tx.tx_ready <= 1'b1;
         tx.tx_done <= 1'b0;
         tx.tx_err <= 1'b0;
      end else begin
         tx.tx_done <= 1'b0;
         tx.tx_err <= 1'b0;
         if (state != IDLE) cnt <= cnt + 1'b1;
         if (go_err) begin
            state <= ERR;
            tx.tx_err <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
         end else
            case (state)
               IDLE: if (tx.tx_valid) begin
                  state <= INHIBIT;
                  cnt <= '0;
                  ps2_clk_oe <= 1'b1;
                  rx_mask <= 1'b1;
                  tx.tx_ready <= 1'b0;
                  sh <= {1'b1, ~^tx.tx_data, tx.tx_data};
               end
               INHIBIT: if (cnt == CW'(INHIBIT_CYC - 1)) begin
                  state <= REQ;
                  cnt <= '0;
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b1;
               end
               // the first fall starts the packet timeout; the tenth hands the stop bit out
               REQ, BITS: if (fall) begin
                  state <= (state == BITS && bitcnt == 4'd9) ? ACK : BITS;
                  ps2_dat_oe <= ~sh[0];
                  sh <= {1'b1, sh[9:1]};
                  bitcnt <= state == REQ ? 4'd1 : bitcnt + 1'b1;
                  if (state == REQ) cnt <= '0;
               end
               ACK: if (fall) state <= REL;
               REL: if (lf[0] & lf[1]) begin
                  state <= DONE;
                  tx.tx_done <= 1'b1;
               end
               default: begin
                  state <= IDLE;
                  cnt <= '0;
                  rx_mask <= 1'b0;
                  tx.tx_ready <= 1'b1;
               end
            endcase
      end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench with an open-drain PS/2 device model
module tb_ps2_host_tx;
   localparam int INH = 100, STO = 2000, PTO = 3000, FL = 8, H = 40;
   localparam int NORM = 0, GLITCH = 1, NACK = 2, NOCLK = 3;
   typedef struct {bit err; logic [9:0] frame;} exp_t;
   logic clk50 = 1'b0, RST = 1'b0, dev_clk = 1'b1, dev_dat = 1'b1;
   logic ps2_clk, ps2_dat, ps2_clk_oe, ps2_dat_oe, rx_mask;
   logic [9:0] dev_cap;
   int cyc = 0, req_cyc = 0, err_cyc = 0, errs = 0, checks = 0;
   exp_t sb[$];
   ps2_host_tx_if tx();
   assign ps2_clk = dev_clk & ~ps2_clk_oe;
   assign ps2_dat = dev_dat & ~ps2_dat_oe;
   ps2_host_tx #(.INHIBIT_CYC(INH), .START_TO_CYC(STO), .PKT_TO_CYC(PTO), .FILT_LEN(FL)) dut (
      .clk50(clk50),
      .RST(RST),
      .tx(tx),
      .PS2_CLK(ps2_clk),
      .PS2_DAT(ps2_dat),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .rx_mask(rx_mask)
   );
   always #10 clk50 = ~clk50;
   always @(posedge clk50) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [9:0] frame_of(input logic [7:0] d);
      logic [9:0] f;
      for (int i = 0; i < 8; i++) f[i] = d[i];
      f[8] = ($countones(d) % 2) == 0;
      f[9] = 1'b1;
      return f;
   endfunction
   task automatic device(input int mode, input int rst_fall);
      int n = 0;
      dev_cap = '0;
      while (!(ps2_clk && !ps2_dat) && n < 5 * INH) begin
         @(negedge clk50);
         n++;
      end
      if (n >= 5 * INH) begin
         chk("request_seen", 0, 1);
         return;
      end
      req_cyc = cyc;
      if (mode == NOCLK) return;
      repeat (H) @(negedge clk50);
      for (int k = 1; k <= 11; k++) begin
         dev_clk = 1'b0;
         if (k == rst_fall) begin
            chk("dat_oe_before_rst", ps2_dat_oe, 1);
            RST = 1'b0;
            #1;
            chk("clk_oe_async_rst", ps2_clk_oe, 0);
            chk("dat_oe_async_rst", ps2_dat_oe, 0);
            chk("ready_async_rst", tx.tx_ready, 1);
            chk("mask_async_rst", rx_mask, 0);
            dev_clk = 1'b1;
            repeat (5) @(negedge clk50);
            RST = 1'b1;
            return;
         end
         if (k == 1) chk("rx_mask_busy", rx_mask, 1);
         if (mode == GLITCH && k == 3) begin
            chk("ready_busy", tx.tx_ready, 0);
            tx.tx_data = 8'h00;
            tx.tx_valid = 1'b1;
            @(negedge clk50);
            tx.tx_valid = 1'b0;
         end
         for (int c = 0; c < H; c++) begin
            @(negedge clk50);
            if (mode == GLITCH && k <= 10 && c == H / 2) begin
               dev_clk = 1'b1;
               @(negedge clk50);
               dev_clk = 1'b0;
            end
         end
         dev_clk = 1'b1;
         if (k <= 10) dev_cap[k-1] = ps2_dat;
         if (k == 11) dev_dat = 1'b1;
         for (int c = 0; c < H; c++) begin
            @(negedge clk50);
            if (mode == GLITCH && k <= 10 && c == H / 4) begin
               dev_clk = 1'b0;
               @(negedge clk50);
               dev_clk = 1'b1;
            end
            if (k == 10 && c == H / 2) dev_dat = mode == NACK;
         end
      end
   endtask
   task automatic send(input logic [7:0] d, input int mode, input int rst_fall);
      int n = 0;
      while (!tx.tx_ready && n < 10000) begin
         @(negedge clk50);
         n++;
      end
      chk("ready_before_send", tx.tx_ready, 1);
      tx.tx_data = d;
      tx.tx_valid = 1'b1;
      if (rst_fall == 0) sb.push_back('{err: mode == NACK || mode == NOCLK, frame: frame_of(d)});
      @(negedge clk50);
      tx.tx_valid = 1'b0;
      tx.tx_data = 8'($urandom);
      device(mode, rst_fall);
      n = 0;
      while (sb.size() != 0 && n < 3 * STO) begin
         @(negedge clk50);
         n++;
      end
      chk("scoreboard_drain", sb.size(), 0);
      if (mode == NOCLK && rst_fall == 0) chk("start_timeout_cycles", err_cyc - req_cyc, STO);
      repeat (3) @(negedge clk50);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk50);
         if (tx.tx_done || tx.tx_err) begin
            if (tx.tx_err) err_cyc = cyc;
            if (sb.size() == 0) chk("unexpected_pulse", {tx.tx_done, tx.tx_err}, 0);
            else begin
               e = sb.pop_front();
               chk("outcome_err", tx.tx_err, e.err);
               chk("outcome_done", tx.tx_done, !e.err);
               if (!e.err) chk("frame_bits", dev_cap, e.frame);
            end
            chk("oe_released", {ps2_clk_oe, ps2_dat_oe}, 0);
            @(negedge clk50);
            chk("ready_after", tx.tx_ready, 1);
            chk("mask_after", rx_mask, 0);
         end
      end
   end
   initial begin
      tx.tx_valid = 1'b0;
      tx.tx_data = 8'h00;
      repeat (3) @(negedge clk50);
      chk("rst_ready", tx.tx_ready, 1);
      chk("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
      chk("rst_mask", rx_mask, 0);
      chk("rst_pulses", {tx.tx_done, tx.tx_err}, 0);
      RST = 1'b1;
      repeat (2) @(negedge clk50);
      send(8'hED, NORM, 0);
      send(8'hF4, NORM, 0);
      send(8'h3C, NOCLK, 0);
      send(8'h12, NACK, 0);
      send(8'hA5, NORM, 5);
      send(8'hFF, NORM, 0);
      send(8'h5A, GLITCH, 0);
      for (int i = 0; i < 8; i++) send(8'($urandom), int'($urandom_range(0, 2)), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
